// File: rtl/lzc_normalizer.sv
// Two-stage mantissa normalizer driven by an upstream leading-zero count.
// Clamps the shift to the exponent headroom and flags underflow.
module lzc_normalizer #(
  parameter int WIDTH = 16,
  parameter int COUNT = $clog2(WIDTH),
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [COUNT:0]   in_z,
  input  logic             in_nv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [COUNT:0]   out_shift,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam logic [COUNT:0] SMAX = (COUNT+1)'(WIDTH-1);
  localparam logic [COUNT:0] SALL = (COUNT+1)'(WIDTH);

  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_nv;
  logic [COUNT:0]   s1_s;
  logic             s2_v;

  logic             s2_load;
  logic             s1_adv;
  logic             s1_load;
  logic [COUNT:0]   s_clamp;

  logic [COUNT:0]   sh;
  logic [EXP_W-1:0] ex;
  logic [WIDTH-1:0] dat;
  logic             uf;
  logic             zr;

  // Handshake: a stage loads when empty or when its beat moves on.
  always_comb begin
    s2_load  = !s2_v || out_ready;
    s1_adv   = s1_v && s2_load;
    s1_load  = !s1_v || s1_adv;
    in_ready = !rst && s1_load;
    s_clamp  = (in_z > SMAX) ? SMAX : in_z;
  end

  assign out_valid = s2_v && !rst;

  // S1 captures the beat together with its clamped shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_exp  <= '0;
      s1_nv   <= 1'b0;
      s1_s    <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_exp  <= in_exp;
        s1_nv   <= in_nv;
        s1_s    <= s_clamp;
      end
    end
  end

  // Limit the shift to the available exponent; zero input wins.
  always_comb begin
    sh  = '0;
    ex  = '0;
    dat = '0;
    uf  = 1'b0;
    zr  = 1'b0;
    if (s1_nv) begin
      sh = SALL;
      zr = 1'b1;
    end else begin
      if (32'(s1_exp) >= 32'(s1_s)) begin
        sh = s1_s;
        ex = s1_exp - EXP_W'(s1_s);
      end else begin
        sh = (COUNT+1)'(s1_exp);
        uf = 1'b1;
      end
      dat = s1_data << sh;
    end
  end

  // S2 holds the normalized result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v      <= 1'b0;
      out_data  <= '0;
      out_exp   <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data  <= dat;
        out_exp   <= ex;
        out_shift <= sh;
        out_zero  <= zr;
        out_uflow <= uf;
      end
    end
  end

endmodule

// File: doc/lzc_normalizer.md
LZC_NORMALIZER -- requirements
Module: lzc_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, mantissa width; a power of 2 and at least 2.
REQ-002 SHALL have parameter COUNT, default $clog2(WIDTH), shift-count width minus one.
REQ-003 SHALL have parameter EXP_W, default 8, exponent width.
REQ-004 clk  input  1  rising-edge clock; sole clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  WIDTH  unnormalized mantissa.
REQ-009 in_exp  input  EXP_W  unsigned biased exponent.
REQ-010 in_z  input  COUNT+1  leading-zero count of in_data from the upstream LZC.
REQ-011 in_nv  input  1  high when in_data is all zeros.
REQ-012 out_valid  output  1  result beat valid.
REQ-013 out_ready  input  1  downstream accepts beat.
REQ-014 out_data  output  WIDTH  normalized mantissa.
REQ-015 out_exp  output  EXP_W  adjusted exponent.
REQ-016 out_shift  output  COUNT+1  left-shift amount applied.
REQ-017 out_zero  output  1  result is zero.
REQ-018 out_uflow  output  1  exponent underflow; partial normalization applied.

Function
REQ-019 SHALL use a two-register pipeline. S1 registers the inputs and computes the clamped shift. S2 registers the shifted data and the adjusted exponent.
REQ-020 SHALL have latency 2 cycles from an accepted beat (in_valid&in_ready) to out_valid, when out_ready is held high.
REQ-021 SHALL sustain throughput of 1 beat per cycle while out_ready=1.
REQ-022 Each stage register SHALL load when it is empty or when its content moves on in the same cycle.
REQ-023 in_ready SHALL be high when S1 is empty or S1 advances this cycle.
REQ-024 out_valid SHALL hold, with out_* data stable, until out_ready=1; beats are never dropped or duplicated, and order is preserved.
REQ-025 in_nv=1: out_data=0, out_exp=0, out_shift=WIDTH, out_zero=1, out_uflow=0; in_nv has priority over in_z.
REQ-026 in_nv=0: s = min(in_z, WIDTH-1).
REQ-027 If in_exp >= s: out_shift=s, out_exp=in_exp-s, out_uflow=0.
REQ-028 If in_exp < s (unsigned): out_shift=in_exp, out_exp=0, out_uflow=1.
REQ-029 out_data SHALL equal in_data << out_shift, zero-filled, truncated to WIDTH bits; out_zero=0 when in_nv=0.
REQ-030 A simultaneous accept and emit SHALL occur in the same cycle without a bubble.
REQ-031 With S1 and S2 both full and out_ready=0, in_ready SHALL be 0.

Reset
REQ-032 While rst=1 at a clk edge: S1/S2 valid bits are cleared, out_valid=0, in_ready=0; data registers are cleared to 0.
REQ-033 The first cycle after rst deasserts SHALL have in_ready=1.
REQ-034 Reset mid-operation SHALL discard all in-flight beats, with no output on the following cycles.

Verification
REQ-035 (WIDTH=16, EXP_W=8) in_data=0x0010, in_exp=20, in_z=11, in_nv=0 -> 2 cycles later: out_data=0x8000, out_exp=9, out_shift=11, out_zero=0, out_uflow=0.
REQ-036 in_data=0x0000, in_nv=1, in_z=16, in_exp=77 -> out_data=0, out_exp=0, out_shift=16, out_zero=1.
REQ-037 in_data=0x0001, in_exp=5, in_z=15 -> out_data=0x0020, out_exp=0, out_shift=5, out_uflow=1.
REQ-038 4 consecutive beats, out_ready=0 for cycles 1-5 -> in_ready=0 after 2 beats are held; after release, all 4 beats emerge in order with no loss.
REQ-039 rst pulsed one cycle with 2 beats in flight -> out_valid=0 on the following cycles; a new beat completes 2 cycles after acceptance.
REQ-040 in_nv=0, in_z=16 (inconsistent), in_data=0x8000, in_exp=40 -> out_shift=15, out_exp=25, out_data=0x0000.
